uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive end of the team's UART: recovers 8-bit characters from the asynchronous `rx` line and checks the optional parity bit with the same `PARITY_ON` and `PARITY_TYPE` semantics that the transmit-side parity generator uses. It sits between the pad and the host-side consumer. Each received character is presented for exactly one cycle as a `valid` strobe, together with its parity and framing status.

## Interface
- `CLK_PER_BIT`, 868: system clocks per bit; must be ≥ 8.
- `PARITY_ON`, 0: 1 = a parity bit follows D7; 0 = no parity bit.
- `PARITY_TYPE`, 1: 1 = odd parity (the parity bit equals `~^data`); 0 = even parity (the parity bit equals `^data`).
- `clk`, in, 1: the single system clock.
- `rst`, in, 1: reset; synchronous and active-high.
- `rx`, in, 1: the serial line. It is asynchronous to `clk` and idles high.
- `data_out`, out, 8: last received character; holds until the next `valid`.
- `valid`, out, 1: one-cycle strobe marking a completed frame.
- `parity_err`, out, 1: parity mismatch for the frame flagged by the most recent `valid`; always 0 when `PARITY_ON=0`.
- `frame_err`, out, 1: the stop bit of that frame was sampled low.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Wire format: start bit (0), then D0..D7 LSB first, then the parity bit if enabled, then one stop bit (1).
- `rx` passes through a 2-flop synchronizer; every reference to `rx` below means the synchronized `rx_s`.
- Constant `MID = (CLK_PER_BIT-1)/2`, using integer division.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - Sets `armed` whenever `rx_s==1`.
  - If `armed` and `rx_s==0`: go to START with `cnt=0`.
- **START**
  - When `cnt==MID`: sample the line.
  - Sample 0: go to DATA with `cnt=0` and `bit_idx=0`.
  - Sample 1: false start; return to IDLE with no strobe.
- **DATA**
  - When `cnt==CLK_PER_BIT-1`: sample the line, shift the sample into `shreg[7]` (right shift), reset `cnt`, increment `bit_idx`.
  - After `bit_idx` 7: go to PARITY if `PARITY_ON`, else STOP.
- **PARITY**: sample at `cnt==CLK_PER_BIT-1`. A mismatch against the expected bit for `PARITY_TYPE` latches the internal `perr`.
- **STOP**: sample at `cnt==CLK_PER_BIT-1`, then on the next edge:
  - `data_out<=shreg`, `parity_err<=perr`, `frame_err<=~sample`, `valid<=1`.
  - Return to IDLE. Clear `armed` if the stop sample was 0 (break/low line), so a held-low line produces exactly one frame.
- Frames with errors still strobe `valid`; the data is delivered unmodified.
- No backpressure: the consumer must take data on `valid`. A new frame simply overwrites `data_out`.

## Timing
- Reset values:
  - `data_out=0`, `valid=0`, `parity_err=0`, `frame_err=0`, `busy=0`.
  - FSM in IDLE, `armed=0`, `cnt=0`, `bit_idx=0`, `shreg=0`.
  - Synchronizer flops = 1.
- Reset asserted mid-frame: all of the above take effect on the next edge. The partial frame is discarded and no `valid` is produced.
- Sample points:
  - Start bit: `MID+1` cycles after entry to START.
  - Every later bit: `CLK_PER_BIT` cycles after the previous sample point.
  - `valid` rises on the cycle after the stop-bit sample point.
- Latency from the pin falling edge to `valid` = 2 (synchronizer) + 1 (IDLE detect) + `MID+1` + N·`CLK_PER_BIT` + 1, where N = 9 without parity and 10 with parity.
- Because IDLE is re-entered at the stop-bit sample point, a back-to-back start bit arriving half a bit later is caught.
- `valid` is never high on two consecutive cycles.
- `busy` goes high on the cycle START is entered and low on the cycle IDLE is re-entered.

## Configuration
- **`UART_RX_MAJORITY_EN` defined**
  - Each sample point takes the majority of `rx_s` at `cnt` = point−1, point, point+1.
  - The +1 sample delays the state update by one cycle at every bit, without accumulating drift: `cnt` is still reset at the nominal point.
  - Latency grows by exactly 1 cycle.
- **Undefined**: each sample point uses the single value of `rx_s` at that point.

## Structure
- Package `uart_pkg`:
  - FSM state enum `rx_state_t`.
  - Localparams `PARITY_EVEN=0` and `PARITY_ODD=1`, shared with the transmit-side parity generator.
  - Function `calc_parity(data, type)` returning the expected parity bit.
- Sub-module `uart_rx_sampler`: the 2-flop synchronizer plus, when `UART_RX_MAJORITY_EN` is defined, the 3-tap majority history. It outputs `rx_s` and `rx_vote`.

## Test plan
Unless stated otherwise, benches use `CLK_PER_BIT=16`.

- **No parity**: send 0xA5 with `PARITY_ON=0` → one `valid` pulse, `data_out=0xA5`, both error flags 0, `valid` at the latency given in Timing.
- **Odd parity**: `PARITY_ON=1`, `PARITY_TYPE=1`.
  - Send 0xA5 with parity bit 1 → `valid`, `parity_err=0`.
  - Resend 0xA5 with parity bit 0 → `valid`, `parity_err=1`, `data_out=0xA5`.
- **Even parity**: `PARITY_TYPE=0`, send 0x07 with parity bit 1 → `parity_err=0`.
- **Framing and break**:
  - Stop bit forced to 0 on 0x3C → `valid`, `frame_err=1`.
  - `rx` held low for 40 bit times → exactly one `valid` (data 0x00, `frame_err=1`), and no further frames until `rx` returns high.
- **False start and back-to-back**:
  - A 4-cycle low glitch on `rx` → no `valid`, `busy` returns to 0.
  - Two back-to-back frames 0x55 then 0xAA with no idle gap → two `valid` pulses carrying 0x55 and 0xAA.
- **Reset mid-frame**: `rst` pulsed during D3 → all outputs 0 and no `valid`; a following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-type encodings and the
// parity helper also used by the transmit-side parity generator.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic calc_parity(input logic [7:0] data, input logic ptype);
        return (ptype == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchronizer for the serial line; with UART_RX_MAJORITY_EN defined it
// also keeps a 3-tap history and votes over the last three synchronized samples.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_vote
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rx_vote = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_vote = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 / 8-parity-1 frames, one-cycle valid strobe with parity and
// framing status. Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int MID   = (CLK_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic PTYPE = (PARITY_TYPE == 1) ? PARITY_ODD : PARITY_EVEN;

    logic rx_s;
    logic rx_vote;

    uart_rx_sampler u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_vote (rx_vote)
    );

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             armed_q, armed_d;
    logic             perr_q, perr_d;
    logic             stop_bit_q, stop_bit_d;
    logic             deliver_q, deliver_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             tick;
    logic             act;

    // tick marks the nominal sample point; act is when the FSM consumes the sample
    always_comb begin
        if (state_q == RX_START) begin
            tick = (cnt_q == CNT_MID);
        end else begin
            tick = (state_q != RX_IDLE) && (cnt_q == CNT_LAST);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so act lags tick by one
    logic act_q, act_d;
    always_comb begin
        act_d = tick;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= 1'b0;
        end else begin
            act_q <= act_d;
        end
    end
    assign act = act_q;
`else
    assign act = tick;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        armed_d      = armed_q;
        perr_d       = perr_q;
        stop_bit_d   = stop_bit_q;
        deliver_d    = 1'b0;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    state_d = RX_START;
                    perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (act) begin
                    if (!rx_vote) begin
                        state_d   = RX_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (act) begin
                    shreg_d   = {rx_vote, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY_ON != 0) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (act) begin
                    if (rx_vote != calc_parity(shreg_q, PTYPE)) begin
                        perr_d = 1'b1;
                    end
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (act) begin
                    // A low stop bit disarms so a held-low line yields only one frame
                    stop_bit_d = rx_vote;
                    armed_d    = rx_vote;
                    deliver_d  = 1'b1;
                    state_d    = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        if (deliver_q) begin
            data_out_d   = shreg_q;
            parity_err_d = perr_q;
            frame_err_d  = ~stop_bit_q;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shreg_q      <= 8'h00;
            armed_q      <= 1'b0;
            perr_q       <= 1'b0;
            stop_bit_q   <= 1'b1;
            deliver_q    <= 1'b0;
            data_out_q   <= 8'h00;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            armed_q      <= armed_d;
            perr_q       <= perr_d;
            stop_bit_q   <= stop_bit_d;
            deliver_q    <= deliver_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances (no parity, odd parity, even parity)
// at 16 clocks per bit, each driven on its own serial line.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int MID = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT_NP = 2 + 1 + (MID + 1) + 9 * CPB + 1 + EXTRA;
    localparam int LAT_P  = 2 + 1 + (MID + 1) + 10 * CPB + 1 + EXTRA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx_l = 3'b111;
    logic [7:0] dout [3];
    logic [2:0] vld;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] bsy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int vcnt [3] = '{0, 0, 0};
    int vcyc [3] = '{0, 0, 0};
    logic [7:0] vdata [3];
    logic [2:0] vpe, vfe;
    logic [2:0] vld_prev = 3'b000;
    int dbl = 0;
    logic [7:0] dq0 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLK_PER_BIT(CPB), .PARITY_ON(0), .PARITY_TYPE(1)) dut_np (
        .clk(clk), .rst(rst), .rx(rx_l[0]), .data_out(dout[0]), .valid(vld[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));
    uart_rx #(.CLK_PER_BIT(CPB), .PARITY_ON(1), .PARITY_TYPE(1)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx_l[1]), .data_out(dout[1]), .valid(vld[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));
    uart_rx #(.CLK_PER_BIT(CPB), .PARITY_ON(1), .PARITY_TYPE(0)) dut_even (
        .clk(clk), .rst(rst), .rx(rx_l[2]), .data_out(dout[2]), .valid(vld[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) begin
                vcnt[i]  = vcnt[i] + 1;
                vcyc[i]  = cyc;
                vdata[i] = dout[i];
                vpe[i]   = pe[i];
                vfe[i]   = fe[i];
                if (vld_prev[i]) dbl = dbl + 1;
                if (i == 0) dq0.push_back(dout[0]);
            end
        end
        vld_prev = vld;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int lane, input logic val, input int n);
        rx_l[lane] = val;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int lane, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop);
        drive(lane, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(lane, d[i], CPB);
        if (par_en) drive(lane, par_bit, CPB);
        drive(lane, stop, CPB);
        rx_l[lane] = 1'b1;
    endtask

    initial begin
        int t0;
        int prev;
        int prev2;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", dout[0], 8'h00);
        chk("rst_valid", vld, 3'b000);
        chk("rst_perr", pe, 3'b000);
        chk("rst_ferr", fe, 3'b000);
        chk("rst_busy", bsy, 3'b000);
        rst = 1'b0;
        drive(0, 1'b1, 8);

        // no parity, 0xA5
        t0 = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("np_count", vcnt[0], 1);
        chk("np_data", vdata[0], 8'hA5);
        chk("np_perr", vpe[0], 1'b0);
        chk("np_ferr", vfe[0], 1'b0);
        chk("np_latency", vcyc[0] - t0, LAT_NP);
        drive(0, 1'b1, 32);

        // odd parity: 0xA5 has four ones, correct parity bit is 1
        t0 = cyc;
        send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
        chk("odd_ok_count", vcnt[1], 1);
        chk("odd_ok_perr", vpe[1], 1'b0);
        chk("odd_ok_latency", vcyc[1] - t0, LAT_P);
        drive(1, 1'b1, 32);
        send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1);
        chk("odd_bad_count", vcnt[1], 2);
        chk("odd_bad_perr", vpe[1], 1'b1);
        chk("odd_bad_data", vdata[1], 8'hA5);
        drive(1, 1'b1, 32);

        // even parity: 0x07 has three ones, correct parity bit is 1
        send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
        chk("even_ok_perr", vpe[2], 1'b0);
        chk("even_ok_data", vdata[2], 8'h07);
        drive(2, 1'b1, 32);
        send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
        chk("even_bad_perr", vpe[2], 1'b1);
        drive(2, 1'b1, 32);

        // framing error on 0x3C
        prev = vcnt[0];
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("frame_count", vcnt[0], prev + 1);
        chk("frame_data", vdata[0], 8'h3C);
        chk("frame_ferr", vfe[0], 1'b1);
        drive(0, 1'b1, 32);

        // break: 40 bit times low
        prev = vcnt[0];
        drive(0, 1'b0, 40 * CPB);
        chk("break_count", vcnt[0], prev + 1);
        chk("break_data", vdata[0], 8'h00);
        chk("break_ferr", vfe[0], 1'b1);
        drive(0, 1'b1, 3 * CPB);
        chk("break_release_count", vcnt[0], prev + 1);
        chk("break_release_busy", bsy[0], 1'b0);

        // 4-cycle glitch: false start
        prev = vcnt[0];
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 4);
        chk("glitch_busy_mid", bsy[0], 1'b1);
        drive(0, 1'b1, 40);
        chk("glitch_busy_end", bsy[0], 1'b0);
        chk("glitch_count", vcnt[0], prev);

        // back-to-back 0x55 then 0xAA
        prev = vcnt[0];
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 32);
        chk("b2b_count", vcnt[0], prev + 2);
        chk("b2b_first", dq0[dq0.size() - 2], 8'h55);
        chk("b2b_second", dq0[dq0.size() - 1], 8'hAA);

        // reset in the middle of D3 of 0x81
        prev = vcnt[0];
        prev2 = vcnt[1];
        drive(0, 1'b0, CPB);
        drive(0, 1'b1, CPB);
        drive(0, 1'b0, CPB);
        drive(0, 1'b0, CPB);
        drive(0, 1'b0, CPB / 2);
        chk("pre_rst_busy", bsy[0], 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_l[0] = 1'b1;
        chk("midrst_data", dout[0], 8'h00);
        chk("midrst_valid", vld[0], 1'b0);
        chk("midrst_busy", bsy[0], 1'b0);
        chk("midrst_flags", {pe[1], fe[0]}, 2'b00);
        chk("midrst_odd_data", dout[1], 8'h00);
        drive(0, 1'b1, 3 * CPB);
        chk("midrst_count", vcnt[0], prev);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        chk("post_rst_count", vcnt[0], prev + 1);
        chk("post_rst_data", vdata[0], 8'h81);
        chk("post_rst_ferr", vfe[0], 1'b0);
        chk("odd_no_spurious", vcnt[1], prev2);
        drive(0, 1'b1, 16);

        chk("no_double_valid", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
